// File: rtl/johnson_pkg.sv
// Shared helpers for the Johnson ring family: code generation, legality
// and phase-index width, used by the RTL and by the reference bench.
package johnson_pkg;

    localparam int MAX_W = 16;

    typedef logic [MAX_W-1:0] code_t;

    function automatic int phase_width(input int width);
        return $clog2(2 * width);
    endfunction

    // Phases 0..width fill from the bottom; later phases drain from the bottom.
    function automatic code_t johnson_code(input int phase, input int width);
        code_t c;
        c = '0;
        if (phase < 0 || phase >= 2 * width) return '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width) begin
                if (phase <= width) c[i] = (i < phase);
                else                c[i] = (i >= phase - width);
            end
        end
        return c;
    endfunction

    function automatic bit johnson_legal(input code_t code, input int width);
        code_t mask;
        mask = (width >= MAX_W) ? '1 : ((code_t'(1) << width) - code_t'(1));
        for (int p = 0; p < 2 * width; p++) begin
            if ((code & mask) == johnson_code(p, width)) return 1'b1;
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/johnson_phase_decode.sv
// Combinational Johnson ring decoder: phase index and legality of q.
// A legal Johnson code has at most one boundary between adjacent bits.
module johnson_phase_decode
    import johnson_pkg::*;
#(
    parameter int WIDTH = 5,
    localparam int PW   = phase_width(WIDTH)
) (
    input  logic [WIDTH-1:0] q,
    output logic [PW-1:0]    phase,
    output logic             legal
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0] ones;
    logic [CW-1:0] edges;
    logic [PW:0]   rev;

    always_comb begin
        ones  = '0;
        edges = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + CW'(q[i]);
        end
        for (int i = 0; i < WIDTH - 1; i++) begin
            edges = edges + CW'(q[i] ^ q[i+1]);
        end
        legal = (edges <= CW'(1));
        rev   = (PW+1)'(2 * WIDTH) - (PW+1)'(ones);
        if (!legal)              phase = '0;
        else if (!q[WIDTH-1])    phase = PW'(ones);
        else                     phase = rev[PW-1:0];
    end

endmodule

// File: rtl/johnson_counter_param.sv
// Parametrised Johnson counter with direction, enable, phase load,
// wrap pulse and illegal-state detection with optional self-correction.
module johnson_counter_param
    import johnson_pkg::*;
#(
    parameter int WIDTH        = 5,
    parameter bit SELF_CORRECT = 1'b1,
    localparam int PW          = phase_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [PW-1:0]    load_phase,
    output logic [WIDTH-1:0] q,
    output logic [PW-1:0]    phase,
    output logic             wrap,
    output logic             illegal
);

    logic             legal;
    logic [WIDTH-1:0] q_nxt;
    logic             wrap_nxt;

    johnson_phase_decode #(.WIDTH(WIDTH)) u_dec (
        .q     (q),
        .phase (phase),
        .legal (legal)
    );

    // Out-of-range load phases come back from johnson_code as all zeros.
    always_comb begin
        q_nxt    = q;
        wrap_nxt = 1'b0;
        if (load) begin
            q_nxt = WIDTH'(johnson_code(int'(load_phase), WIDTH));
        end else if (!legal && SELF_CORRECT) begin
            q_nxt = '0;
        end else if (en) begin
            if (!dir) begin
                q_nxt    = {q[WIDTH-2:0], ~q[WIDTH-1]};
                wrap_nxt = legal && (phase == PW'(2 * WIDTH - 1));
            end else begin
                q_nxt    = {~q[0], q[WIDTH-1:1]};
                wrap_nxt = legal && (phase == '0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q       <= '0;
            wrap    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            q       <= q_nxt;
            wrap    <= wrap_nxt;
            illegal <= !legal;
        end
    end

endmodule

// File: doc/johnson_counter_param.md
# johnson_counter_param

Parametrised Johnson (twisted-ring) counter and the next generation of the lab 8 sequence-generator blocks. It generates 2*WIDTH glitch-free states with selectable direction, enable and parallel phase load. It also decodes the current phase index, pulses on wrap-around, and detects and optionally self-corrects illegal ring states. It is intended as a reusable timing and phase source for sequencers and multiplexed-display drivers.

## Interface
- WIDTH, 5, ring width in bits, legal range 2..16; the counter has 2*WIDTH states.
- SELF_CORRECT, 1, when 1 an illegal state is forced to phase 0 on the next edge; when 0 it is only flagged.
- PW (localparam), $clog2(2*WIDTH), width of the phase index.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  step enable.
- dir  in  1  0 = up (forward), 1 = down (reverse).
- load  in  1  synchronous parallel load of a phase.
- load_phase  in  PW  phase index to load.
- q  out  WIDTH  ring register.
- phase  out  PW  decoded phase index of q, 0..2*WIDTH-1.
- wrap  out  1  registered one-cycle pulse on wrap-around.
- illegal  out  1  registered one-cycle pulse, high when q held a non-Johnson code before the edge.

## Operation
- Legal code for phase p:
  - p ≤ WIDTH: the lowest p bits are set.
  - p > WIDTH: the top 2*WIDTH-p bits are set.
  - Example, WIDTH=5: 00000, 00001, 00011, 00111, 01111, 11111, 11110, 11100, 11000, 10000.
- Up step: q ← {q[WIDTH-2:0], ~q[WIDTH-1]}. Down step: q ← {~q[0], q[WIDTH-1:1]}. Each step moves exactly one phase, modulo 2*WIDTH.
- Per-edge priority, highest first:
  1. rst.
  2. load: q ← code(load_phase). If load_phase ≥ 2*WIDTH, phase 0 is loaded. The values of en and dir are ignored.
  3. Illegal q with SELF_CORRECT=1: q ← 0, regardless of en.
  4. en=1: step in direction dir.
  5. Otherwise hold.
- illegal ← (q before the edge is not a legal code). This applies whatever the priority outcome. With SELF_CORRECT=0, stepping continues on the raw bits.
- wrap ← 1 only on a step edge that moves phase 2*WIDTH-1→0 (up) or 0→2*WIDTH-1 (down); 0 otherwise.
  - A load, a correction or a hold never raises wrap.
- phase, combinational from q:
  - q[WIDTH-1]=0: phase = popcount(q).
  - q[WIDTH-1]=1: phase = 2*WIDTH - popcount(q).
  - Illegal q: phase = 0.

## Timing
- Reset values: q=0, phase=0, wrap=0, illegal=0.
- Asserting rst clears every register immediately, with no clock needed, including mid-count. Deassertion is a synchronous release, and the first step occurs on the first rising edge with rst=0 and en=1.
- Latency:
  - A step, load or correction is visible on q and phase one edge after its inputs are sampled.
  - wrap and illegal are updated on that same edge and are high for exactly one cycle.
- A change of dir while en=1 takes effect on the next edge, with no dead cycle: a forward step is immediately followed by a reverse step back to the prior phase.
- en held high gives one phase per cycle. The full cycle is 2*WIDTH clocks.
- Exactly one q bit toggles per step.

## Structure
- Shared package johnson_pkg:
  - function johnson_code(phase, width) → code.
  - function johnson_legal(code, width) → bit.
  - function phase_width(width) → $clog2(2*width).
  - The testbench reuses all three for its reference model.
- One sub-module, johnson_phase_decode: combinational q → {phase, legal}. It is instantiated once in the counter and reused standalone by display drivers.
- The counter top holds the ring register, the next-state mux and the wrap/illegal flops.

## Test plan
- Count up: WIDTH=5, rst 1→0, en=1, dir=0 for 10 cycles → q = 00001, 00011, 00111, 01111, 11111, 11110, 11100, 11000, 10000, 00000; phase = 1..9, 0; wrap=1 only in the cycle q returns to 00000.
- Count down: from reset, en=1, dir=1 → q=10000 with phase 9 and wrap=1, then 11000 with phase 8 and wrap=0. Toggling dir to 0 → 10000.
- Hold and load:
  - en=0 for 4 cycles → q unchanged.
  - load=1, load_phase=7 → q=11100, phase=7, wrap=0.
  - load_phase=12 → q=00000.
  - load=1 with en=1 → the load wins.
- Illegal state: force q=01010 for one edge.
  - SELF_CORRECT=1: next edge q=00000 and illegal=1 for 1 cycle, then counting resumes 00001.
  - SELF_CORRECT=0: illegal stays 1 while q remains illegal, and phase=0.
- Async reset: assert rst between edges at q=00111 → q=00000, phase=0, wrap=0 before the next clock edge. After release, the first enabled edge gives q=00001.
- Minimum width: WIDTH=2, en=1, dir=0 → q = 01, 11, 10, 00; wrap on 00; PW=2.
